// File: rtl/stream_demux_1x2_if.sv
// Handshake bundle for stream_demux_1x2: one input stream and two output streams.
// slave = router side, master = surrounding environment.
interface stream_demux_1x2_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sel;

    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out0_data;

    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out1_data;

    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/stream_demux_1x2.sv
// Registered 1-to-2 stream router, one holding register per output port.
// Optional per-port saturating beat counters (cnt0/cnt1) when DEMUX_CNT_EN is defined.
module stream_demux_1x2 #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_demux_1x2_if.slave   bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [CW-1:0]       cnt0,
    output logic [CW-1:0]       cnt1
`endif
);

    if (DW < 1 || CW < 1) begin : g_param_check
        $error("stream_demux_1x2: DW and CW must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e        state_q [2];
    state_e        state_d [2];
    logic [DW-1:0] data_q  [2];
    logic [DW-1:0] data_d  [2];

    logic [1:0] ready;
    logic [1:0] valid;
    logic [1:0] acc_to;
    logic [1:0] pop;
    logic       in_ready;
    logic       acc;

    // in_ready depends only on the selected port, never on in_valid.
    always_comb begin
        ready     = {bus.out1_ready, bus.out0_ready};
        in_ready  = !valid[bus.in_sel] | ready[bus.in_sel];
        acc       = bus.in_valid & in_ready;
        acc_to[0] = acc & !bus.in_sel;
        acc_to[1] = acc &  bus.in_sel;
        pop       = valid & ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            case (state_q[i])
                EMPTY:   if (acc_to[i])             state_d[i] = FULL;
                FULL:    if (pop[i] && !acc_to[i])  state_d[i] = EMPTY;
                default:                            state_d[i] = EMPTY;
            endcase
            // Data survives the pop; it changes only when a new beat lands here.
            if (acc_to[i]) data_d[i] = bus.in_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            valid[i] = (state_q[i] == FULL);
        end
        bus.in_ready   = in_ready;
        bus.out0_valid = valid[0];
        bus.out0_data  = data_q[0];
        bus.out1_valid = valid[1];
        bus.out1_data  = data_q[1];
    end

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Saturate at all-ones instead of wrapping.
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pop[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CW'(1);
        end
    end

    always_comb begin
        cnt0 = cnt_q[0];
        cnt1 = cnt_q[1];
    end
`endif

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Self-checking bench for stream_demux_1x2: vector table, directed corner cases,
// then random traffic against a queue-based reference model.
module tb_stream_demux_1x2;
    localparam int DW = 8;
`ifdef DEMUX_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_demux_1x2_if #(.DW(DW)) ifc ();
`ifdef DEMUX_CNT_EN
    logic [CW-1:0] cnt0, cnt1;
`endif

    stream_demux_1x2 #(.DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each output is a capacity-1 FIFO, data shows the last beat routed there.
    typedef logic [DW-1:0] beat_t;
    beat_t mq0[$];
    beat_t mq1[$];
    beat_t last0, last1;
    int    mcnt0, mcnt1;

    bit    cur_v, cur_s, cur_r0, cur_r1;
    beat_t cur_d;

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        last0 = '0;
        last1 = '0;
        mcnt0 = 0;
        mcnt1 = 0;
    endtask

    function automatic bit m_ir();
        if (cur_s) return (mq1.size() == 0) || cur_r1;
        return (mq0.size() == 0) || cur_r0;
    endfunction

    task automatic model_clock();
        bit acc;
        beat_t tmp;
        acc = cur_v && m_ir();
        if (cur_r0 && mq0.size() > 0) begin
            tmp = mq0.pop_front();
            if (mcnt0 < CMAX) mcnt0++;
        end
        if (cur_r1 && mq1.size() > 0) begin
            tmp = mq1.pop_front();
            if (mcnt1 < CMAX) mcnt1++;
        end
        if (acc) begin
            if (cur_s) begin mq1.push_back(cur_d); last1 = cur_d; end
            else       begin mq0.push_back(cur_d); last0 = cur_d; end
        end
    endtask

    task automatic drive(input bit v, input bit s, input beat_t d, input bit r0, input bit r1);
        cur_v = v; cur_s = s; cur_d = d; cur_r0 = r0; cur_r1 = r1;
        ifc.in_valid   = v;
        ifc.in_sel     = s;
        ifc.in_data    = d;
        ifc.out0_ready = r0;
        ifc.out1_ready = r1;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".v0"}, 32'(ifc.out0_valid), 32'(mq0.size() != 0));
        chk({tag, ".d0"}, 32'(ifc.out0_data),  32'(last0));
        chk({tag, ".v1"}, 32'(ifc.out1_valid), 32'(mq1.size() != 0));
        chk({tag, ".d1"}, 32'(ifc.out1_data),  32'(last1));
`ifdef DEMUX_CNT_EN
        chk({tag, ".c0"}, 32'(cnt0), 32'(mcnt0));
        chk({tag, ".c1"}, 32'(cnt1), 32'(mcnt1));
`endif
    endtask

    // Called at posedge+1: apply inputs, check in_ready, clock, check registered outputs.
    task automatic step(input string tag, input bit v, input bit s, input beat_t d,
                        input bit r0, input bit r1);
        drive(v, s, d, r0, r1);
        #1;
        chk({tag, ".ir"}, 32'(ifc.in_ready), 32'(m_ir()));
        @(posedge clk);
        model_clock();
        #1;
        check_out(tag);
    endtask

    typedef struct {
        bit v; bit s; logic [7:0] d; bit r0; bit r1;
        bit ir; bit v0; logic [7:0] d0; bit v1; logic [7:0] d1; int c0; int c1;
    } vec_t;

    vec_t tv [9];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          v  s  d      r0 r1 ir v0 d0     v1 d1     c0 c1
        tv[0] = '{1, 0, 8'hA5, 1, 1, 1, 1, 8'hA5, 0, 8'h00, 0, 0};
        tv[1] = '{1, 1, 8'h3C, 1, 1, 1, 0, 8'hA5, 1, 8'h3C, 1, 0};
        tv[2] = '{0, 0, 8'hFF, 1, 1, 1, 0, 8'hA5, 0, 8'h3C, 1, 1};
        tv[3] = '{1, 1, 8'h11, 1, 0, 1, 0, 8'hA5, 1, 8'h11, 1, 1};
        tv[4] = '{1, 1, 8'h22, 1, 0, 0, 0, 8'hA5, 1, 8'h11, 1, 1};
        tv[5] = '{1, 0, 8'h33, 1, 0, 1, 1, 8'h33, 1, 8'h11, 1, 1};
        tv[6] = '{1, 0, 8'h44, 0, 0, 0, 1, 8'h33, 1, 8'h11, 1, 1};
        tv[7] = '{1, 1, 8'h22, 0, 1, 1, 1, 8'h33, 1, 8'h22, 1, 2};
        tv[8] = '{0, 0, 8'h00, 1, 1, 1, 0, 8'h33, 0, 8'h22, 2, 3};

        // Reset with a beat offered: nothing may load.
        rst_n = 1'b0;
        drive(1, 0, 8'hFF, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ir", 32'(ifc.in_ready), 32'd1);
        chk("rst.v0", 32'(ifc.out0_valid), 32'd0);
        chk("rst.d0", 32'(ifc.out0_data), 32'd0);
        chk("rst.v1", 32'(ifc.out1_valid), 32'd0);
        chk("rst.d1", 32'(ifc.out1_data), 32'd0);
`ifdef DEMUX_CNT_EN
        chk("rst.c0", 32'(cnt0), 32'd0);
        chk("rst.c1", 32'(cnt1), 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tv[i].v, tv[i].s, tv[i].d, tv[i].r0, tv[i].r1);
            #1;
            chk($sformatf("tv%0d.ir", i), 32'(ifc.in_ready), 32'(tv[i].ir));
            @(posedge clk);
            model_clock();
            #1;
            chk($sformatf("tv%0d.v0", i), 32'(ifc.out0_valid), 32'(tv[i].v0));
            chk($sformatf("tv%0d.d0", i), 32'(ifc.out0_data),  32'(tv[i].d0));
            chk($sformatf("tv%0d.v1", i), 32'(ifc.out1_valid), 32'(tv[i].v1));
            chk($sformatf("tv%0d.d1", i), 32'(ifc.out1_data),  32'(tv[i].d1));
`ifdef DEMUX_CNT_EN
            chk($sformatf("tv%0d.c0", i), 32'(cnt0), 32'(tv[i].c0));
            chk($sformatf("tv%0d.c1", i), 32'(cnt1), 32'(tv[i].c1));
`endif
        end

        // Eight back-to-back beats to out0 with out0_ready held high.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("b2b%0d", i), 1, 0, beat_t'(8'h50 + i), 1, 1);
            chk($sformatf("b2b%0d.ir1", i), 32'(ifc.in_ready), 32'd1);
            chk($sformatf("b2b%0d.v0c", i), 32'(ifc.out0_valid), 32'd1);
            chk($sformatf("b2b%0d.d0c", i), 32'(ifc.out0_data), 32'(8'h50 + i));
        end
        step("drain", 0, 0, 8'h00, 1, 1);
`ifdef DEMUX_CNT_EN
        chk("sat.c0", 32'(cnt0), 32'(CMAX));
`endif

        // Reset pulse while out1 is full and stalled.
        step("fill1", 1, 1, 8'h77, 1, 0);
        drive(0, 0, 8'h00, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.v1", 32'(ifc.out1_valid), 32'd0);
        chk("arst.d1", 32'(ifc.out1_data), 32'd0);
`ifdef DEMUX_CNT_EN
        chk("arst.c1", 32'(cnt1), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post", 0, 0, 8'h00, 1, 1);

        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 beat_t'($urandom), bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
